// File: rtl/debounce_pkg.sv
// Shared definitions for the single-channel debouncer: legal timer width
// range and the two-state stability machine encoding.
package debounce_pkg;

    localparam int DEB_TIMER_WIDTH_MIN = 1;
    localparam int DEB_TIMER_WIDTH_MAX = 32;

    // The state bit doubles as the debounced output level.
    typedef enum logic {
        STABLE_LOW  = 1'b0,
        STABLE_HIGH = 1'b1
    } deb_state_e;

endpackage

// File: rtl/debounce_block.sv
// Single-channel debouncer. The raw input is brought into the clock domain
// through a two-flop synchronizer; the debounced level only follows it after
// the synchronized value has disagreed with the output for 2^TIMER_WIDTH
// consecutive edges. A bounce back to the current level restarts the count.
// One-cycle rise/fall pulses mark each output change.
module debounce_block
    import debounce_pkg::*;
#(
    parameter int TIMER_WIDTH = 22
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall
);

    // Reject unusable counter widths at elaboration.
    if (TIMER_WIDTH < DEB_TIMER_WIDTH_MIN || TIMER_WIDTH > DEB_TIMER_WIDTH_MAX) begin : g_bad_width
        $fatal(1, "debounce_block: TIMER_WIDTH out of range");
    end

    localparam logic [TIMER_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [TIMER_WIDTH-1:0] CNT_ONE = TIMER_WIDTH'(1);

    logic                   sync1;
    logic                   sync2;
    logic [TIMER_WIDTH-1:0] cnt;
    logic [TIMER_WIDTH-1:0] cnt_nxt;
    deb_state_e             state;
    deb_state_e             state_nxt;
    logic                   rise_nxt;
    logic                   fall_nxt;

    // The registered state bit is the debounced level.
    assign out = (state == STABLE_HIGH);

    // Two-flop synchronizer for the asynchronous raw input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
        end
    end

    // State, stability counter and edge-pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= STABLE_LOW;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    // Next-state logic: count while the synchronized input disagrees with the
    // output, flip the output when the counter is already saturated. The
    // terminal check sits ahead of the increment so the counter never wraps.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        if (sync2 == out) begin
            cnt_nxt = '0;
        end else if (cnt == CNT_MAX) begin
            cnt_nxt   = '0;
            state_nxt = sync2 ? STABLE_HIGH : STABLE_LOW;
            rise_nxt  = sync2;
            fall_nxt  = ~sync2;
        end else begin
            cnt_nxt = cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_debounce_block.sv
// Bench for debounce_block: two instances (TIMER_WIDTH=3 and 1) share clock,
// reset and input. A sliding-window model of the debouncing rule predicts
// out/rise/fall for every edge; directed scenarios add fixed-latency checks.
module tb_debounce_block;

    logic clk = 1'b0;
    logic rst;
    logic in_sig;
    logic out3, rise3, fall3;
    logic out1, rise1, fall1;

    debounce_block #(.TIMER_WIDTH(3)) dut_w3 (
        .clk (clk),
        .rst (rst),
        .in  (in_sig),
        .out (out3),
        .rise(rise3),
        .fall(fall3)
    );

    debounce_block #(.TIMER_WIDTH(1)) dut_w1 (
        .clk (clk),
        .rst (rst),
        .in  (in_sig),
        .out (out1),
        .rise(rise1),
        .fall(fall1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: raw samples per edge since reset, and for each
    // instance its output, pulses and edges since the last output change.
    bit hist[0:63];
    int ecount;
    int since[2];
    bit mout[2];
    bit mrise[2];
    bit mfall[2];
    int win[2] = '{8, 2};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Synchronized level seen by the debounce logic at edge e: the raw value
    // sampled two edges earlier, or the reset value 0 before that exists.
    function automatic bit delayed(input int e);
        int j;
        j = e - 2;
        if (j < 1) return 1'b0;
        return hist[6'(j)];
    endfunction

    task automatic model_reset();
        ecount = 0;
        for (int m = 0; m < 2; m++) begin
            since[m] = 0;
            mout[m]  = 1'b0;
            mrise[m] = 1'b0;
            mfall[m] = 1'b0;
        end
    endtask

    // The output flips at an edge when the synchronized level disagreed with
    // it on each of the last N edges, all of them after the previous change.
    task automatic model_step(input bit v);
        bit ok;
        ecount++;
        hist[6'(ecount)] = v;
        for (int m = 0; m < 2; m++) begin
            since[m]++;
            mrise[m] = 1'b0;
            mfall[m] = 1'b0;
            if (since[m] >= win[m]) begin
                ok = 1'b1;
                for (int k = 0; k < win[m]; k++)
                    if (delayed(ecount - k) == mout[m]) ok = 1'b0;
                if (ok) begin
                    mout[m]  = ~mout[m];
                    mrise[m] = mout[m];
                    mfall[m] = ~mout[m];
                    since[m] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("out_w3",  32'(out3),  32'(mout[0]));
        check("rise_w3", 32'(rise3), 32'(mrise[0]));
        check("fall_w3", 32'(fall3), 32'(mfall[0]));
        check("out_w1",  32'(out1),  32'(mout[1]));
        check("rise_w1", 32'(rise1), 32'(mrise[1]));
        check("fall_w1", 32'(fall1), 32'(mfall[1]));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out_w3"},  32'(out3),  32'd0);
        check({tag, "_rise_w3"}, 32'(rise3), 32'd0);
        check({tag, "_fall_w3"}, 32'(fall3), 32'd0);
        check({tag, "_out_w1"},  32'(out1),  32'd0);
        check({tag, "_rise_w1"}, 32'(rise1), 32'd0);
        check({tag, "_fall_w1"}, 32'(fall1), 32'd0);
    endtask

    // One clock: drive the input mid-cycle, take the edge, step the model,
    // compare just after the edge.
    task automatic tick(input bit v);
        in_sig = v;
        @(posedge clk);
        model_step(v);
        #1;
        compare_all();
    endtask

    // Called 1 time unit after an edge: assert reset between edges and
    // confirm the outputs clear without waiting for a clock.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_zero(tag);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n_r;
        int r_at;
        int nt;
        bit lvl;
        int hold;

        rst    = 1'b1;
        in_sig = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Clean rise
        for (int i = 1; i <= 11; i++) begin
            tick(1'b1);
            if (i == 3)  check("rise_w1_e3_out", 32'(out1), 32'd0);
            if (i == 4)  check("rise_w1_e4_out", 32'(out1), 32'd1);
            if (i == 9)  check("rise_e9_out",  32'(out3),  32'd0);
            if (i == 10) check("rise_e10_out", 32'(out3),  32'd1);
            if (i == 10) check("rise_e10_pls", 32'(rise3), 32'd1);
            if (i == 11) check("rise_e11_pls", 32'(rise3), 32'd0);
        end

        // Clean fall
        n_r = 0;
        for (int i = 1; i <= 11; i++) begin
            tick(1'b0);
            if (rise3) n_r++;
            if (i == 9)  check("fall_e9_out",  32'(out3),  32'd1);
            if (i == 10) check("fall_e10_out", 32'(out3),  32'd0);
            if (i == 10) check("fall_e10_pls", 32'(fall3), 32'd1);
            if (i == 11) check("fall_e11_pls", 32'(fall3), 32'd0);
        end
        check("fall_no_rise", 32'(n_r), 32'd0);

        // Glitch rejection: 7 sampled high edges, one short of the window
        n_r = 0;
        for (int i = 0; i < 7; i++)  begin tick(1'b1); if (rise3) n_r++; end
        for (int i = 0; i < 12; i++) begin tick(1'b0); if (rise3) n_r++; end
        check("glitch_out",     32'(out3), 32'd0);
        check("glitch_no_rise", 32'(n_r),  32'd0);
        for (int i = 1; i <= 10; i++) begin
            tick(1'b1);
            if (i == 10) check("glitch_hold_out", 32'(out3),  32'd1);
            if (i == 10) check("glitch_hold_pls", 32'(rise3), 32'd1);
        end
        // Reset while the rise pulse is high
        async_reset("pulse_rst");

        // Reset mid-count
        for (int i = 0; i < 6; i++) tick(1'b1);
        async_reset("mid_rst");
        for (int i = 1; i <= 10; i++) begin
            tick(1'b1);
            if (i == 3)  check("mid_w1_e3_out", 32'(out1), 32'd0);
            if (i == 4)  check("mid_w1_e4_out", 32'(out1), 32'd1);
            if (i == 9)  check("mid_e9_out",  32'(out3), 32'd0);
            if (i == 10) check("mid_e10_out", 32'(out3), 32'd1);
        end

        // Bounce train then settle high
        for (int i = 0; i < 12; i++) tick(1'b0);
        n_r  = 0;
        r_at = -1;
        for (int i = 0; i < 40; i++) begin
            tick(((i / 2) % 2) == 0);
            if (rise3) n_r++;
        end
        for (int i = 1; i <= 12; i++) begin
            tick(1'b1);
            if (rise3) begin n_r++; r_at = i; end
        end
        check("bounce_rise_cnt", 32'(n_r),  32'd1);
        check("bounce_rise_at",  32'(r_at), 32'd10);

        // Randomized hold lengths with occasional asynchronous resets
        nt = 0;
        while (nt < 3000) begin
            lvl  = 1'($urandom_range(0, 1));
            hold = int'($urandom_range(1, 12));
            for (int i = 0; i < hold; i++) begin
                tick(lvl);
                nt++;
            end
            if ($urandom_range(0, 49) == 0) async_reset("rand_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
